// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: boundary/pin inputs and datapath step strobes of the interrupt sequencer.
interface interrupt_sequencer_if;
   logic        nmi_n;
   logic        irq_n;
   logic        i_flag;
   logic        brk_req;
   logic        fetch_ready;
   logic        rdy;
   logic        int_busy;
   logic        push_pch;
   logic        push_pcl;
   logic        push_p;
   logic        push_we;
   logic        sp_dec;
   logic        b_push;
   logic        vec_lo_rd;
   logic        vec_hi_rd;
   logic [15:0] vec_addr;
   logic        set_i;
   logic        int_done;

   modport master (
      output nmi_n, irq_n, i_flag, brk_req, fetch_ready, rdy,
      input  int_busy, push_pch, push_pcl, push_p, push_we, sp_dec, b_push,
             vec_lo_rd, vec_hi_rd, vec_addr, set_i, int_done
   );

   modport slave (
      input  nmi_n, irq_n, i_flag, brk_req, fetch_ready, rdy,
      output int_busy, push_pch, push_pcl, push_p, push_we, sp_dec, b_push,
             vec_lo_rd, vec_hi_rd, vec_addr, set_i, int_done
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 6502 RESET/NMI/BRK/IRQ entry - pushes PC and P, fetches the vector, sets I.
module interrupt_sequencer (
   input logic                  ph2,
   input logic                  reset,
   interrupt_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} state_t;
   typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_BRK, SRC_IRQ} src_t;

   state_t      r_state, w_state_nxt;
   src_t        r_src, w_src_nxt;
   logic [15:0] r_vec, w_vec_nxt;
   logic        r_nmi_q, r_nmi_pend, r_rst_pend;
   logic        w_nmi_edge, w_nmi_clr, w_start, w_push;

   assign w_nmi_edge = r_nmi_q & ~bus.nmi_n;

   always_ff @(posedge ph2) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_src      <= SRC_RST;
         r_vec      <= 16'h0000;
         r_nmi_q    <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_rst_pend <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_src      <= w_src_nxt;
         r_vec      <= w_vec_nxt;
         r_nmi_q    <= bus.nmi_n;
         r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
         r_rst_pend <= r_rst_pend & ~w_start;
      end
   end

   // A fresh NMI edge in the clearing cycle wins over the clear above.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_vec_nxt   = r_vec;
      w_start     = 1'b0;
      w_nmi_clr   = 1'b0;
      if (bus.rdy) begin
         case (r_state)
            IDLE: begin
               w_start     = r_rst_pend | (bus.fetch_ready &
                             (r_nmi_pend | bus.brk_req | (~bus.irq_n & ~bus.i_flag)));
               w_src_nxt   = !w_start ? r_src : r_rst_pend ? SRC_RST : r_nmi_pend ? SRC_NMI :
                             bus.brk_req ? SRC_BRK : SRC_IRQ;
               w_state_nxt = w_start ? PUSH_PCH : IDLE;
            end
            PUSH_PCH: w_state_nxt = PUSH_PCL;
            PUSH_PCL: w_state_nxt = PUSH_P;
            PUSH_P: begin
               w_state_nxt = VEC_LO;
               w_vec_nxt   = r_src == SRC_RST ? 16'hFFFC :
                             (r_src == SRC_NMI || r_nmi_pend) ? 16'hFFFA : 16'hFFFE;
               w_nmi_clr   = w_vec_nxt == 16'hFFFA;
            end
            VEC_LO:  w_state_nxt = VEC_HI;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_push        = r_state inside {PUSH_PCH, PUSH_PCL, PUSH_P};
   assign bus.int_busy  = r_state != IDLE;
   assign bus.push_pch  = r_state == PUSH_PCH;
   assign bus.push_pcl  = r_state == PUSH_PCL;
   assign bus.push_p    = r_state == PUSH_P;
   assign bus.sp_dec    = w_push;
   assign bus.push_we   = w_push & (r_src != SRC_RST);
   assign bus.b_push    = (r_state == PUSH_P) & (r_src == SRC_BRK);
   assign bus.vec_lo_rd = r_state == VEC_LO;
   assign bus.vec_hi_rd = r_state == VEC_HI;
   assign bus.set_i     = r_state == VEC_LO;
   assign bus.int_done  = r_state == VEC_HI;
   assign bus.vec_addr  = r_state == VEC_LO ? r_vec :
                          r_state == VEC_HI ? r_vec + 16'd1 : 16'h0000;
endmodule
